// File: rtl/fft16_pkg.sv
// ============================================================================
// Module : fft16_pkg
// Brief  : Shared types and helpers for the FFT16 result streamer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft16_pkg;

    localparam int POINTS_LOG2 = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    function automatic logic [POINTS_LOG2-1:0] bitrev4(input logic [POINTS_LOG2-1:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    // The most negative code has no positive twin, so it clamps to the largest positive value.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned width);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (width - 1));
        if (x == most_neg) begin
            return (32'd1 << (width - 1)) - 32'd1;
        end else if (x < 0) begin
            return $unsigned(-x);
        end else begin
            return $unsigned(x);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft16_frame_buffer.sv
// ============================================================================
// Module : fft16_frame_buffer
// Brief  : Two-slot (active + pending) frame register file with read mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft16_frame_buffer
    import fft16_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int POINTS    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_active,
    input  logic                          i_wr_pending,
    input  logic                          i_promote,
    input  logic [POINTS*WORD_SIZE-1:0]   i_frame_re,
    input  logic [POINTS*WORD_SIZE-1:0]   i_frame_im,
    input  logic [POINTS_LOG2-1:0]        i_rd_idx,
    output logic [WORD_SIZE-1:0]          o_rd_re,
    output logic [WORD_SIZE-1:0]          o_rd_im
);

    logic [WORD_SIZE-1:0] r_act_re  [POINTS];
    logic [WORD_SIZE-1:0] r_act_im  [POINTS];
    logic [WORD_SIZE-1:0] r_pend_re [POINTS];
    logic [WORD_SIZE-1:0] r_pend_im [POINTS];

    // Promote and write-pending may coincide: active takes the old pending frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < POINTS; k++) begin
                r_act_re[k]  <= '0;
                r_act_im[k]  <= '0;
                r_pend_re[k] <= '0;
                r_pend_im[k] <= '0;
            end
        end else begin
            for (int k = 0; k < POINTS; k++) begin
                if (i_wr_active) begin
                    r_act_re[k] <= i_frame_re[k*WORD_SIZE +: WORD_SIZE];
                    r_act_im[k] <= i_frame_im[k*WORD_SIZE +: WORD_SIZE];
                end else if (i_promote) begin
                    r_act_re[k] <= r_pend_re[k];
                    r_act_im[k] <= r_pend_im[k];
                end
                if (i_wr_pending) begin
                    r_pend_re[k] <= i_frame_re[k*WORD_SIZE +: WORD_SIZE];
                    r_pend_im[k] <= i_frame_im[k*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    assign o_rd_re = r_act_re[i_rd_idx];
    assign o_rd_im = r_act_im[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/fft16_result_streamer.sv
// ============================================================================
// Module : fft16_result_streamer
// Brief  : Captures FFT16 parallel results and replays them as a valid/ready
//          serial stream with one pending frame of buffering.
//          Optional magnitude output enabled by FFT16_STREAM_MAG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft16_result_streamer
    import fft16_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8,
    parameter int POINTS    = 16,
    parameter int OUT_ORDER = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [POINTS*WORD_SIZE-1:0]   i_frame_re,
    input  logic [POINTS*WORD_SIZE-1:0]   i_frame_im,
    input  logic                          i_FFT_cycle_done,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [WORD_SIZE-1:0]          o_re,
    output logic [WORD_SIZE-1:0]          o_im,
    output logic [3:0]                    o_index,
    output logic                          o_last,
    output logic                          o_busy,
    output logic                          o_overrun,
    output logic [7:0]                    o_drop_cnt
`ifdef FFT16_STREAM_MAG_EN
    ,
    output logic [WORD_SIZE-1:0]          o_mag
`endif
);

    generate
        if (POINTS != 16 || FRACTION >= WORD_SIZE) begin : g_param_check
            $error("fft16_result_streamer: POINTS must be 16 and FRACTION < WORD_SIZE");
        end
    endgenerate

    stream_state_t          r_state;
    logic [POINTS_LOG2-1:0] r_seq;
    logic                   r_pend_full;
    logic                   r_done_d;
    logic                   r_overrun;
    logic [7:0]             r_drop_cnt;

    logic w_streaming;
    logic w_capture;
    logic w_accept;
    logic w_last_acc;
    logic w_wr_active;
    logic w_wr_pending;
    logic w_promote;
    logic w_drop;

    assign w_streaming = (r_state == STREAM);
    assign w_capture   = i_FFT_cycle_done & ~r_done_d;
    assign w_accept    = w_streaming & i_ready;
    assign w_last_acc  = w_accept & (r_seq == 4'd15);

    // A capture on the last accepted beat refills whichever slot is freed.
    assign w_wr_active  = w_capture & (~w_streaming | (w_last_acc & ~r_pend_full));
    assign w_promote    = w_last_acc & r_pend_full;
    assign w_wr_pending = w_capture & w_streaming & (w_last_acc ? r_pend_full : ~r_pend_full);
    assign w_drop       = w_capture & w_streaming & ~w_last_acc & r_pend_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_seq       <= '0;
            r_pend_full <= 1'b0;
            r_done_d    <= 1'b0;
            r_overrun   <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_done_d    <= i_FFT_cycle_done;
            r_overrun   <= w_drop;
            r_pend_full <= (r_pend_full & ~w_promote) | w_wr_pending;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_state <= STREAM;
                        r_seq   <= '0;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (r_seq == 4'd15) begin
                            r_seq <= '0;
                            if (!r_pend_full && !w_capture) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_seq <= r_seq + 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        if (OUT_ORDER != 0) begin : g_bitrev_order
            assign o_index = bitrev4(r_seq);
        end else begin : g_natural_order
            assign o_index = r_seq;
        end
    endgenerate

    fft16_frame_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .POINTS    (POINTS)
    ) u_frame_buffer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_active  (w_wr_active),
        .i_wr_pending (w_wr_pending),
        .i_promote    (w_promote),
        .i_frame_re   (i_frame_re),
        .i_frame_im   (i_frame_im),
        .i_rd_idx     (o_index),
        .o_rd_re      (o_re),
        .o_rd_im      (o_im)
    );

    assign o_valid    = w_streaming;
    assign o_last     = w_streaming & (r_seq == 4'd15);
    assign o_busy     = w_streaming | r_pend_full;
    assign o_overrun  = r_overrun;
    assign o_drop_cnt = r_drop_cnt;

`ifdef FFT16_STREAM_MAG_EN
    localparam logic [32:0] c_mag_max = 33'((64'd1 << WORD_SIZE) - 64'd1);

    logic [31:0] w_abs_re;
    logic [31:0] w_abs_im;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [32:0] w_mag_sum;

    // Alpha-max-plus-beta-min estimate with alpha = 1, beta = 1/2.
    always_comb begin
        w_abs_re  = sat_abs(32'($signed(o_re)), WORD_SIZE);
        w_abs_im  = sat_abs(32'($signed(o_im)), WORD_SIZE);
        w_big     = (w_abs_re > w_abs_im) ? w_abs_re : w_abs_im;
        w_small   = (w_abs_re > w_abs_im) ? w_abs_im : w_abs_re;
        w_mag_sum = {1'b0, w_big} + {1'b0, (w_small >> 1)};
        o_mag     = (w_mag_sum > c_mag_max) ? c_mag_max[WORD_SIZE-1:0] : w_mag_sum[WORD_SIZE-1:0];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft16_result_streamer.sv
// ============================================================================
// Module : tb_fft16_result_streamer
// Brief  : Self-checking bench; natural-order and bit-reversed instances share stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft16_result_streamer;

    typedef struct {
        logic [15:0] re [16];
        logic [15:0] im [16];
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         done = 1'b0;
    logic         ready = 1'b0;
    logic [255:0] frame_re = '0;
    logic [255:0] frame_im = '0;

    logic        o_valid0, o_last0, o_busy0, o_ovr0;
    logic        o_valid1, o_last1, o_busy1, o_ovr1;
    logic [15:0] o_re0, o_im0, o_re1, o_im1;
    logic [3:0]  o_idx0, o_idx1;
    logic [7:0]  o_drop0, o_drop1;
`ifdef FFT16_STREAM_MAG_EN
    logic [15:0] o_mag0, o_mag1;
`endif

    fft16_result_streamer #(.WORD_SIZE(16), .FRACTION(8), .POINTS(16), .OUT_ORDER(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_frame_re(frame_re), .i_frame_im(frame_im),
        .i_FFT_cycle_done(done), .i_ready(ready), .o_valid(o_valid0), .o_re(o_re0),
        .o_im(o_im0), .o_index(o_idx0), .o_last(o_last0), .o_busy(o_busy0),
        .o_overrun(o_ovr0), .o_drop_cnt(o_drop0)
`ifdef FFT16_STREAM_MAG_EN
        , .o_mag(o_mag0)
`endif
    );

    fft16_result_streamer #(.WORD_SIZE(16), .FRACTION(8), .POINTS(16), .OUT_ORDER(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_frame_re(frame_re), .i_frame_im(frame_im),
        .i_FFT_cycle_done(done), .i_ready(ready), .o_valid(o_valid1), .o_re(o_re1),
        .o_im(o_im1), .o_index(o_idx1), .o_last(o_last1), .o_busy(o_busy1),
        .o_overrun(o_ovr1), .o_drop_cnt(o_drop1)
`ifdef FFT16_STREAM_MAG_EN
        , .o_mag(o_mag1)
`endif
    );

    always #5 clk = ~clk;

    // Data fields only matter while a beat is valid.
    logic [47:0] w_act0, w_act1;
    assign w_act0 = {o_valid0, o_last0, o_busy0, o_ovr0, o_drop0, o_valid0 ? {o_idx0, o_re0, o_im0} : 36'd0};
    assign w_act1 = {o_valid1, o_last1, o_busy1, o_ovr1, o_drop1, o_valid1 ? {o_idx1, o_re1, o_im1} : 36'd0};

    // Reference model: a queue of at most two frames; the head is the one streaming.
    frame_t cur;
    frame_t q[$];
    int     m_pos = 0;
    int     m_drop = 0;
    bit     m_ovr = 1'b0;
    bit     m_prev_done = 1'b0;

    int checks = 0;
    int passed = 0;

    task automatic set_frame(input frame_t f);
        cur = f;
        for (int k = 0; k < 16; k++) begin
            frame_re[k*16 +: 16] = f.re[k];
            frame_im[k*16 +: 16] = f.im[k];
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < 16; k++) begin
            f.re[k] = 16'($urandom);
            f.im[k] = 16'($urandom);
        end
        return f;
    endfunction

    function automatic logic [3:0] order(input int p, input bit rev);
        logic [3:0] b;
        b = p[3:0];
        return rev ? {b[0], b[1], b[2], b[3]} : b;
    endfunction

    function automatic logic [47:0] exp_vec(input bit rev);
        logic [3:0] idx;
        idx = order(m_pos, rev);
        if (q.size() == 0) return {3'b000, m_ovr, 8'(m_drop), 36'd0};
        return {1'b1, (m_pos == 15), 1'b1, m_ovr, 8'(m_drop), idx, q[0].re[idx], q[0].im[idx]};
    endfunction

    function automatic int ref_mag(input logic [15:0] re, input logic [15:0] im);
        int a, b, hi, lo, s;
        a = int'($signed(re));
        b = int'($signed(im));
        a = (a == -32768) ? 32767 : ((a < 0) ? -a : a);
        b = (b == -32768) ? 32767 : ((b < 0) ? -b : b);
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        s = hi + lo / 2;
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pos = 0;
        m_drop = 0;
        m_ovr = 1'b0;
        m_prev_done = 1'b0;
    endtask

    task automatic tick();
        bit cap, acc;
        cap = done && !m_prev_done;
        acc = (q.size() > 0) && ready;
        @(posedge clk);
        m_prev_done = done;
        m_ovr = 1'b0;
        if (acc) begin
            if (m_pos == 15) begin
                q.delete(0);
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (cap) begin
            if (q.size() < 2) begin
                q.push_back(cur);
            end else begin
                m_ovr = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        done = 1'b0;
        ready = 1'b0;
        set_frame(rand_frame());
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_valid0, o_last0, o_busy0, o_ovr0, o_valid1, o_last1, o_busy1, o_ovr1} !== 8'd0)
            $display("FAIL reset_ctrl got %b%b%b%b %b%b%b%b exp all 0", o_valid0, o_last0, o_busy0, o_ovr0, o_valid1, o_last1, o_busy1, o_ovr1);
        else passed++;
        checks++;
        if ({o_idx0, o_re0, o_im0, o_idx1, o_re1, o_im1} !== 72'd0)
            $display("FAIL reset_data got idx=%h re=%h im=%h exp 0", o_idx0, o_re0, o_im0);
        else passed++;
        checks++;
        if ({o_drop0, o_drop1} !== 16'd0) $display("FAIL reset_drop got %h/%h exp 0", o_drop0, o_drop1);
        else passed++;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL reset_idle got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
        end
    endtask

    task automatic test_single_frame();
        frame_t f;
        int n, lasts;
        for (int k = 0; k < 16; k++) begin
            f.re[k] = 16'(k * 256);
            f.im[k] = 16'(-k);
        end
        set_frame(f);
        ready = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (o_valid0 !== 1'b1 || o_idx0 !== 4'd0)
            $display("FAIL single_latency got valid=%b idx=%0d exp valid=1 idx=0", o_valid0, o_idx0);
        else passed++;
        n = 0;
        lasts = 0;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL single_beat got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
            if (o_valid0 && ready) begin
                n++;
                if (o_last0) lasts++;
            end
            tick();
        end
        checks++;
        if (n !== 16 || lasts !== 1 || o_valid0 !== 1'b0 || o_busy0 !== 1'b0)
            $display("FAIL single_count got beats=%0d lasts=%0d valid=%b busy=%b exp 16 1 0 0", n, lasts, o_valid0, o_busy0);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n;
        n = 0;
        set_frame(rand_frame());
        for (int c = 0; c < 200 && (c == 0 || q.size() > 0); c++) begin
            done = (c == 0);
            ready = pat[c % 4];
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL backpressure got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
            if (o_valid0 && ready) n++;
            tick();
        end
        done = 1'b0;
        checks++;
        if (n !== 16) $display("FAIL backpressure_count got %0d exp 16", n);
        else passed++;
    endtask

    task automatic test_overrun();
        bit sent2, sent3;
        int n, pulses;
        sent2 = 1'b0;
        sent3 = 1'b0;
        n = 0;
        pulses = 0;
        ready = 1'b1;
        for (int c = 0; c < 100 && (c == 0 || q.size() > 0); c++) begin
            done = 1'b0;
            if (c == 0) begin
                set_frame(rand_frame());
                done = 1'b1;
            end else if (!sent2 && q.size() == 1 && m_pos == 5) begin
                set_frame(rand_frame());
                done = 1'b1;
                sent2 = 1'b1;
            end else if (sent2 && !sent3 && q.size() == 2 && m_pos == 8) begin
                set_frame(rand_frame());
                done = 1'b1;
                sent3 = 1'b1;
            end
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL overrun_beat got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
            if (o_valid0 && ready) n++;
            if (o_ovr0) pulses++;
            tick();
        end
        done = 1'b0;
        checks++;
        if (n !== 32 || pulses !== 1 || o_drop0 !== 8'd1)
            $display("FAIL overrun_summary got beats=%0d pulses=%0d drop=%0d exp 32 1 1", n, pulses, o_drop0);
        else passed++;
    endtask

    task automatic test_coincident();
        bit sent2;
        int n, pulses;
        sent2 = 1'b0;
        n = 0;
        pulses = 0;
        ready = 1'b1;
        for (int c = 0; c < 100 && (c == 0 || q.size() > 0); c++) begin
            done = 1'b0;
            if (c == 0) begin
                set_frame(rand_frame());
                done = 1'b1;
            end else if (!sent2 && q.size() == 1 && m_pos == 15) begin
                set_frame(rand_frame());
                done = 1'b1;
                sent2 = 1'b1;
            end
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL coincident_beat got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
            if (o_valid0 && ready) n++;
            if (o_ovr0) pulses++;
            tick();
        end
        done = 1'b0;
        checks++;
        if (n !== 32 || pulses !== 0 || o_drop0 !== 8'd1)
            $display("FAIL coincident_summary got beats=%0d pulses=%0d drop=%0d exp 32 0 1", n, pulses, o_drop0);
        else passed++;
    endtask

    task automatic test_out_order();
        logic [3:0] tbl [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
        int n;
        n = 0;
        ready = 1'b1;
        set_frame(rand_frame());
        for (int c = 0; c < 40 && (c == 0 || q.size() > 0); c++) begin
            done = (c == 0);
            if (o_valid1 && ready && n < 16) begin
                checks++;
                if (o_idx1 !== tbl[n]) $display("FAIL out_order beat %0d got %0d exp %0d", n, o_idx1, tbl[n]);
                else passed++;
                n++;
            end
            tick();
        end
        done = 1'b0;
        checks++;
        if (n !== 16) $display("FAIL out_order_count got %0d exp 16", n);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) done = ~done;
            set_frame(rand_frame());
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL random_beat got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
`ifdef FFT16_STREAM_MAG_EN
            if (o_valid0) begin
                checks++;
                if (int'(o_mag0) != ref_mag(o_re0, o_im0))
                    $display("FAIL random_mag got %h exp %h", o_mag0, ref_mag(o_re0, o_im0));
                else passed++;
            end
`endif
            tick();
        end
        done = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) tick();
        checks++;
        if (w_act0 !== exp_vec(1'b0) || o_valid0 !== 1'b0)
            $display("FAIL random_drain got %h exp %h", w_act0, exp_vec(1'b0));
        else passed++;
    endtask

    task automatic test_reset_midstream();
        int n;
        ready = 1'b1;
        set_frame(rand_frame());
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int c = 0; c < 20 && !(q.size() > 0 && m_pos == 7); c++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({o_valid0, o_last0, o_busy0, o_ovr0, o_drop0, o_idx0, o_re0, o_im0} !== 48'd0)
            $display("FAIL midreset_zero got v=%b busy=%b drop=%0d idx=%0d re=%h im=%h exp all 0", o_valid0, o_busy0, o_drop0, o_idx0, o_re0, o_im0);
        else passed++;
        model_reset();
        set_frame(rand_frame());
        done = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (o_valid0 !== 1'b1 || o_idx0 !== 4'd0) $display("FAIL midreset_restart got valid=%b idx=%0d exp 1 0", o_valid0, o_idx0);
        else passed++;
        n = 0;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            checks++;
            if (w_act0 !== exp_vec(1'b0) || w_act1 !== exp_vec(1'b1))
                $display("FAIL midreset_beat got %h/%h exp %h/%h", w_act0, w_act1, exp_vec(1'b0), exp_vec(1'b1));
            else passed++;
            if (o_valid0 && ready) n++;
            tick();
        end
        done = 1'b0;
        checks++;
        if (n !== 16) $display("FAIL midreset_count got %0d exp 16", n);
        else passed++;
    endtask

`ifdef FFT16_STREAM_MAG_EN
    task automatic test_mag();
        frame_t f;
        f = rand_frame();
        f.re[0] = 16'h0300;
        f.im[0] = 16'hFF00;
        set_frame(f);
        ready = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (o_valid0 !== 1'b1 || o_mag0 !== 16'h0380) $display("FAIL mag_fixed got valid=%b mag=%h exp 1 0380", o_valid0, o_mag0);
        else passed++;
        for (int c = 0; c < 40 && q.size() > 0; c++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_coincident();
        test_out_order();
        test_random();
        test_reset_midstream();
`ifdef FFT16_STREAM_MAG_EN
        test_mag();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
